// File: rtl/mem_access_stage_bus.sv
// MEM pipeline stage with an external request/grant/response data-memory bus.
// Holds the instruction until the access completes (or times out), builds
// store strobes/lane data, extends load data and flags misaligned accesses.
module mem_access_stage_bus #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e_to_m_valid,
  input  logic              w_allow_in,
  output logic              m_allow_in,
  output logic              m_to_w_valid,
  output logic              m_valid,
  input  logic [6:0]        E_opcode,
  input  logic [9:0]        E_funct,
  input  logic [31:0]       e_valE,
  input  logic [31:0]       E_val2,
  input  logic [4:0]        E_rd,
  input  logic [31:0]       E_default_pc,
  input  logic [31:0]       E_cur_pc,
  input  logic [31:0]       E_instr,
  input  logic              E_commit,
  input  logic [31:0]       E_pred_pc,
  input  logic              can_jump,
  input  logic [31:0]       jump_target,
  output logic [6:0]        M_opcode,
  output logic [9:0]        M_funct,
  output logic [31:0]       M_valE,
  output logic [31:0]       M_val2,
  output logic [4:0]        M_rd,
  output logic [31:0]       M_default_pc,
  output logic [31:0]       M_cur_pc,
  output logic [31:0]       M_instr,
  output logic              M_commit,
  output logic [31:0]       M_pred_pc,
  output logic [31:0]       m_valM,
  output logic              m_misalign,
  output logic              m_bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wstrb,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_valid;
  logic [6:0]        r_opcode;
  logic [9:0]        r_funct;
  logic [31:0]       r_valE;
  logic [31:0]       r_val2;
  logic [4:0]        r_rd;
  logic [31:0]       r_default_pc;
  logic [31:0]       r_cur_pc;
  logic [31:0]       r_instr;
  logic              r_commit;
  logic [31:0]       r_pred_pc;
  logic [31:0]       r_valM;
  logic              r_misalign;
  logic              r_bus_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic [1:0]        w_size;
  logic [1:0]        w_off;
  logic              w_mis;
  logic              w_e_mem;
  logic              w_e_mis;
  logic              w_ready_go;
  logic              w_m_allow_in;
  logic              w_capture;
  logic              w_timeout_hit;
  logic              w_timeout;
  logic [31:0]       w_lane;
  logic [31:0]       w_load_ext;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;

  // Half accesses need an even address, word (and the unused size 11) a 4-byte one.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   f_misaligned = 1'b0;
      2'b01:   f_misaligned = off[0];
      default: f_misaligned = (off != 2'b00);
    endcase
  endfunction

  assign w_is_load  = (r_opcode == OP_LOAD);
  assign w_is_store = (r_opcode == OP_STORE);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_size     = r_funct[1:0];
  assign w_off      = r_valE[1:0];
  assign w_mis      = w_is_mem & f_misaligned(w_size, w_off);

  assign w_e_mem    = (E_opcode == OP_LOAD) | (E_opcode == OP_STORE);
  assign w_e_mis    = f_misaligned(E_funct[1:0], e_valE[1:0]);

  assign w_timeout  = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST_C);

  assign w_m_allow_in = ~r_valid | (w_ready_go & w_allow_in);

  // Stage may hand off: non-memory and misaligned ops at once, memory ops once done.
  always_comb begin
    w_ready_go = 1'b0;
    case (r_state)
      S_IDLE:  w_ready_go = ~w_is_mem | w_mis;
      S_DONE:  w_ready_go = 1'b1;
      default: w_ready_go = 1'b0;
    endcase
  end

  // Bus FSM next state; completing events take priority over the watchdog.
  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_valid & w_is_mem & ~w_mis) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (dmem_gnt & w_is_store) begin
          w_state_nxt = S_DONE;
        end else if (dmem_gnt & dmem_rvalid) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt   = S_DONE;
          w_timeout_hit = 1'b1;
        end else if (dmem_gnt) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt   = S_DONE;
          w_timeout_hit = 1'b1;
        end
      end
      S_DONE: begin
        if (w_m_allow_in) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Select the addressed lane and sign/zero extend it.
  always_comb begin
    w_lane     = dmem_rdata >> {w_off, 3'b000};
    w_load_ext = w_lane;
    case (r_funct[2:0])
      3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_ext = {24'h000000, w_lane[7:0]};
      3'b101:  w_load_ext = {16'h0000, w_lane[15:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    w_wstrb = '0;
    w_wdata = r_val2;
    if (w_is_store) begin
      case (w_size)
        2'b00: begin
          w_wstrb = 4'b0001 << w_off;
          w_wdata = {4{r_val2[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << w_off;
          w_wdata = {2{r_val2[15:0]}};
        end
        default: begin
          w_wstrb = 4'hF;
          w_wdata = r_val2;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Watchdog: restarts on entry to ISSUE, counts through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((r_state != S_ISSUE) && (w_state_nxt == S_ISSUE)) begin
      r_cnt <= '0;
    end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Occupancy and instruction payload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_funct      <= '0;
      r_valE       <= '0;
      r_val2       <= '0;
      r_rd         <= '0;
      r_default_pc <= '0;
      r_cur_pc     <= '0;
      r_instr      <= '0;
      r_commit     <= 1'b0;
      r_pred_pc    <= '0;
    end else if (w_m_allow_in) begin
      r_valid <= e_to_m_valid;
      if (e_to_m_valid) begin
        r_opcode     <= E_opcode;
        r_funct      <= E_funct;
        r_valE       <= e_valE;
        r_val2       <= E_val2;
        r_rd         <= E_rd;
        r_default_pc <= E_default_pc;
        r_cur_pc     <= E_cur_pc;
        r_instr      <= E_instr;
        r_commit     <= E_commit;
        r_pred_pc    <= can_jump ? jump_target : E_pred_pc;
      end
    end
  end

  // Result/status: cleared when the stage advances, misalign known at capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valM     <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else if (w_m_allow_in) begin
      r_valM     <= '0;
      r_bus_err  <= 1'b0;
      r_misalign <= e_to_m_valid & w_e_mem & w_e_mis;
    end else begin
      if (w_capture) r_valM <= w_load_ext;
      if (w_timeout_hit) begin
        r_valM    <= '0;
        r_bus_err <= 1'b1;
      end
    end
  end

  assign m_allow_in   = w_m_allow_in;
  assign m_to_w_valid = r_valid & w_ready_go;
  assign m_valid      = r_valid;

  assign M_opcode     = r_opcode;
  assign M_funct      = r_funct;
  assign M_valE       = r_valE;
  assign M_val2       = r_val2;
  assign M_rd         = r_rd;
  assign M_default_pc = r_default_pc;
  assign M_cur_pc     = r_cur_pc;
  assign M_instr      = r_instr;
  assign M_commit     = r_commit;
  assign M_pred_pc    = r_pred_pc;
  assign m_valM       = r_valM;
  assign m_misalign   = r_misalign;
  assign m_bus_err    = r_bus_err;

  assign dmem_req     = (r_state == S_ISSUE);
  assign dmem_we      = w_is_store;
  assign dmem_addr    = {r_valE[ADDR_W-1:2], 2'b00};
  assign dmem_wstrb   = w_wstrb;
  assign dmem_wdata   = w_wdata;

endmodule

// File: tb/tb_mem_access_stage_bus.sv
// Directed bench for mem_access_stage_bus with a spec-level model of each
// instruction's expected bus transaction, result and latency.
module tb_mem_access_stage_bus;

  localparam int TO = 4;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        e_to_m_valid = 1'b0;
  logic        w_allow_in = 1'b1;
  logic        m_allow_in, m_to_w_valid, m_valid;
  logic [6:0]  E_opcode = '0;
  logic [9:0]  E_funct = '0;
  logic [31:0] e_valE = '0, E_val2 = '0;
  logic [4:0]  E_rd = 5'd7;
  logic [31:0] E_default_pc = 32'h100, E_cur_pc = 32'hFC, E_instr = '0;
  logic        E_commit = 1'b1;
  logic [31:0] E_pred_pc = '0;
  logic        can_jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [6:0]  M_opcode;
  logic [9:0]  M_funct;
  logic [31:0] M_valE, M_val2, M_default_pc, M_cur_pc, M_instr, M_pred_pc, m_valM;
  logic [4:0]  M_rd;
  logic        M_commit, m_misalign, m_bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'hDEADBEEF;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // expected values for the instruction currently in the stage
  bit          exp_req_ok, exp_we, exp_mis, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_valM, exp_valE, exp_pred, exp_instr;
  logic [3:0]  exp_wstrb;

  // observations of the last run_op
  int          obs_lat;
  logic [31:0] obs_addr, obs_wdata, obs_valM;
  logic [3:0]  obs_wstrb;
  logic        obs_mis, obs_err;

  mem_access_stage_bus #(.ADDR_W(32), .TIMEOUT_CYC(TO), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .e_to_m_valid(e_to_m_valid), .w_allow_in(w_allow_in),
    .m_allow_in(m_allow_in), .m_to_w_valid(m_to_w_valid), .m_valid(m_valid),
    .E_opcode(E_opcode), .E_funct(E_funct), .e_valE(e_valE), .E_val2(E_val2),
    .E_rd(E_rd), .E_default_pc(E_default_pc), .E_cur_pc(E_cur_pc), .E_instr(E_instr),
    .E_commit(E_commit), .E_pred_pc(E_pred_pc), .can_jump(can_jump), .jump_target(jump_target),
    .M_opcode(M_opcode), .M_funct(M_funct), .M_valE(M_valE), .M_val2(M_val2), .M_rd(M_rd),
    .M_default_pc(M_default_pc), .M_cur_pc(M_cur_pc), .M_instr(M_instr), .M_commit(M_commit),
    .M_pred_pc(M_pred_pc), .m_valM(m_valM), .m_misalign(m_misalign), .m_bus_err(m_bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---- model: access size in bytes, alignment, strobes, lanes, extension
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] size, input logic [1:0] off);
    return (int'(off) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [1:0] size, input logic [1:0] off);
    int s;
    s = ((1 << nbytes(size)) - 1) << int'(off);
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] v);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = v[8*(b % nbytes(size)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
    int n;
    logic [63:0] v, mask;
    n = nbytes(f3[1:0]);
    mask = (64'd1 << (8*n)) - 64'd1;
    v = ({32'd0, rd} >> (8*int'(off))) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Per-cycle compare against the model for the instruction in the stage.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      if (dmem_req) begin
        chk("req_allowed", 32'(dmem_req), 32'(exp_req_ok));
        chk("req_addr", dmem_addr, exp_addr);
        chk("req_we", 32'(dmem_we), 32'(exp_we));
        chk("req_wstrb", 32'(dmem_wstrb), 32'(exp_wstrb));
        if (exp_we) chk("req_wdata", dmem_wdata, exp_wdata);
      end
      if (m_to_w_valid) begin
        chk("valM", m_valM, exp_valM);
        chk("misalign", 32'(m_misalign), 32'(exp_mis));
        chk("bus_err", 32'(m_bus_err), 32'(exp_err));
        chk("M_valE", M_valE, exp_valE);
        chk("M_pred_pc", M_pred_pc, exp_pred);
        chk("M_instr", M_instr, exp_instr);
      end
    end
  end

  // Issue one instruction, act as the memory, wait for hand-off.
  task automatic run_op(input string nm, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] val2, input logic [31:0] rdata,
                        input int gnt_dly, input int rv_dly, input bit no_gnt, input int stall,
                        input bit jmp);
    int cyc, reqs, gnt_at, done_idx, exp_lat, exp_reqs;
    bit seen, allow_ok, is_ld, is_st, mis, err;
    @(posedge clk);
    is_ld = (op == LD);
    is_st = (op == ST);
    mis = (is_ld | is_st) && model_mis(f3[1:0], addr[1:0]);
    done_idx = no_gnt ? 1000 : (is_st ? gnt_dly : gnt_dly + rv_dly);
    err = (is_ld | is_st) && !mis && (done_idx >= TO);
    exp_req_ok = (is_ld | is_st) && !mis;
    exp_we    = is_st;
    exp_addr  = {addr[31:2], 2'b00};
    exp_wstrb = is_st ? model_wstrb(f3[1:0], addr[1:0]) : 4'h0;
    exp_wdata = model_wdata(f3[1:0], val2);
    exp_valM  = (is_ld && !mis && !err) ? model_load(f3, addr[1:0], rdata) : 32'h0;
    exp_mis   = mis;
    exp_err   = err;
    exp_valE  = addr;
    exp_pred  = jmp ? (32'hC0DE_0000 ^ addr) : addr + 32'd4;
    exp_instr = addr ^ 32'h5A5A_5A5A;
    if (!exp_req_ok) begin
      exp_lat = 0; exp_reqs = 0;
    end else if (err) begin
      exp_lat = 1 + TO;
      exp_reqs = no_gnt ? TO : ((gnt_dly + 1 < TO) ? gnt_dly + 1 : TO);
    end else begin
      exp_lat = 2 + done_idx; exp_reqs = gnt_dly + 1;
    end
    @(negedge clk);
    chk({nm, "_allow_in_empty"}, 32'(m_allow_in), 32'd1);
    E_opcode = op; E_funct = {7'b0, f3}; e_valE = addr; E_val2 = val2;
    E_pred_pc = addr + 32'd4; can_jump = jmp; jump_target = 32'hC0DE_0000 ^ addr;
    E_instr = addr ^ 32'h5A5A_5A5A; e_to_m_valid = 1'b1;
    reqs = 0; gnt_at = -1; seen = 0; allow_ok = 1; obs_lat = -1;
    for (cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      e_to_m_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hDEADBEEF;
      if (m_to_w_valid) begin
        seen = 1; obs_lat = cyc - 1;
        obs_valM = m_valM; obs_mis = m_misalign; obs_err = m_bus_err;
        chk({nm, "_req_low_at_done"}, 32'(dmem_req), 32'd0);
        if (stall > 0) w_allow_in = 1'b0;
      end else begin
        if (m_allow_in) allow_ok = 0;
        if (dmem_req) begin
          if (reqs == 0) begin
            obs_addr = dmem_addr; obs_wstrb = dmem_wstrb; obs_wdata = dmem_wdata;
          end
          if (!no_gnt && reqs == gnt_dly) begin dmem_gnt = 1'b1; gnt_at = cyc; end
          reqs++;
        end
        if (is_ld && gnt_at > 0 && cyc == gnt_at + rv_dly) begin
          dmem_rvalid = 1'b1; dmem_rdata = rdata;
        end
      end
    end
    chk({nm, "_completed"}, 32'(seen), 32'd1);
    chk({nm, "_latency"}, obs_lat, exp_lat);
    chk({nm, "_req_cycles"}, reqs, exp_reqs);
    chk({nm, "_stalled_upstream"}, 32'(allow_ok), 32'd1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(m_to_w_valid), 32'd1);
      chk({nm, "_no_second_req"}, 32'(dmem_req), 32'd0);
      chk({nm, "_hold_allow"}, 32'(m_allow_in), 32'd0);
    end
    w_allow_in = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_valM", m_valM, 32'd0);
    chk("rst_misalign", 32'(m_misalign), 32'd0);
    chk("rst_bus_err", 32'(m_bus_err), 32'd0);
    chk("rst_M_valE", M_valE, 32'd0);
    chk("rst_M_pred_pc", M_pred_pc, 32'd0);
    chk("rst_allow_in", 32'(m_allow_in), 32'd1);
    rst = 1'b1;
    chk_en = 1'b1;

    run_op("alu", ALU, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0, 0, 1);
    chk("alu_lat_lit", obs_lat, 0);
    chk("alu_pred_lit", M_pred_pc, 32'hC0DE_1234);

    run_op("sb", ST, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 0, 0, 0);
    chk("sb_wstrb_lit", 32'(obs_wstrb), 32'h8);
    chk("sb_wdata_lit", obs_wdata, 32'hABAB_ABAB);
    chk("sb_addr_lit", obs_addr, 32'h0000_1000);
    chk("sb_lat_lit", obs_lat, 2);

    run_op("sh", ST, 3'b001, 32'h0000_1002, 32'h1234_CDEF, 32'h0, 0, 0, 0, 0, 0);
    chk("sh_wstrb_lit", 32'(obs_wstrb), 32'hC);
    chk("sh_wdata_lit", obs_wdata, 32'hCDEF_CDEF);

    run_op("sw_late_gnt", ST, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, 3, 0, 0, 0, 0);
    chk("sw_err_lit", 32'(obs_err), 32'd0);
    chk("sw_lat_lit", obs_lat, 5);

    run_op("lh", LD, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 3, 0, 0, 0);
    chk("lh_valM_lit", obs_valM, 32'hFFFF_8001);
    chk("lh_lat_lit", obs_lat, 5);

    run_op("lhu", LD, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 3, 0, 0, 0);
    chk("lhu_valM_lit", obs_valM, 32'h0000_8001);

    run_op("lb", LD, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0, 0, 0, 0);
    chk("lb_valM_lit", obs_valM, 32'hFFFF_FF80);
    chk("lb_lat_lit", obs_lat, 2);

    run_op("lbu", LD, 3'b100, 32'h0000_2003, 32'h0, 32'h7F00_0000, 1, 1, 0, 0, 0);
    chk("lbu_valM_lit", obs_valM, 32'h0000_007F);

    run_op("lw_mis", LD, 3'b010, 32'h0000_3001, 32'h0, 32'h1111_1111, 0, 0, 0, 0, 0);
    chk("lw_mis_flag_lit", 32'(obs_mis), 32'd1);
    chk("lw_mis_valM_lit", obs_valM, 32'd0);

    run_op("sh_mis", ST, 3'b001, 32'h0000_3003, 32'h5555_5555, 32'h0, 0, 0, 0, 0, 0);

    run_op("lw_timeout", LD, 3'b010, 32'h0000_4000, 32'h0, 32'h2222_2222, 0, 0, 1, 0, 0);
    chk("to_err_lit", 32'(obs_err), 32'd1);
    chk("to_lat_lit", obs_lat, 5);

    run_op("lw_stall", LD, 3'b010, 32'h0000_5000, 32'h0, 32'h1234_5678, 0, 1, 0, 3, 0);
    chk("stall_valM_lit", obs_valM, 32'h1234_5678);

    // reset while a load waits for its response
    @(posedge clk);
    exp_req_ok = 1; exp_we = 0; exp_addr = 32'h0000_6000; exp_wstrb = 4'h0;
    @(negedge clk);
    E_opcode = LD; E_funct = 10'b010; e_valE = 32'h0000_6000; can_jump = 1'b0;
    e_to_m_valid = 1'b1;
    @(negedge clk);
    e_to_m_valid = 1'b0;
    @(negedge clk);
    chk("rstw_req_issued", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rstw_waiting", 32'(m_allow_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = 32'hDEADBEEF;
    chk("rstw_m_valid", 32'(m_valid), 32'd0);
    chk("rstw_valM", m_valM, 32'd0);
    chk("rstw_to_w_valid", 32'(m_to_w_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw_idle_req", 32'(dmem_req), 32'd0);
      chk("rstw_idle_allow", 32'(m_allow_in), 32'd1);
    end

    run_op("lw_after_rst", LD, 3'b010, 32'h0000_6004, 32'h0, 32'hA5A5_A5A5, 0, 0, 0, 0, 0);
    chk("recover_valM_lit", obs_valM, 32'hA5A5_A5A5);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
